// File: rtl/pipe_stage_reg_if.sv
// Bundle of signals between a pipeline stage and its inter-stage register.
// The master modport is the upstream stage/hazard unit; the slave modport is the register.
interface pipe_stage_reg_if #(
  parameter int NUM_WORDS = 2,
  parameter int TNEW_W    = 2,
  parameter int CNT_W     = 16
);
  logic                    en;
  logic                    flush;
  logic                    valid_i;
  logic                    reg_write_i;
  logic                    mem_to_reg_i;
  logic                    link_i;
  logic [4:0]              a3_i;
  logic [TNEW_W-1:0]       tnew_i;
  logic [31:0]             pc_i;
  logic [NUM_WORDS*32-1:0] payload_i;

  logic                    valid_o;
  logic                    reg_write_o;
  logic                    mem_to_reg_o;
  logic                    link_o;
  logic [4:0]              a3_o;
  logic [TNEW_W-1:0]       tnew_o;
  logic [31:0]             pc_o;
  logic [31:0]             pc8_o;
  logic [NUM_WORDS*32-1:0] payload_o;
  logic                    fwd_ready_o;
  logic [CNT_W-1:0]        stall_cnt_o;
  logic [CNT_W-1:0]        bubble_cnt_o;

  modport master (
    output en, flush, valid_i, reg_write_i, mem_to_reg_i, link_i,
           a3_i, tnew_i, pc_i, payload_i,
    input  valid_o, reg_write_o, mem_to_reg_o, link_o, a3_o, tnew_o,
           pc_o, pc8_o, payload_o, fwd_ready_o, stall_cnt_o, bubble_cnt_o
  );

  modport slave (
    input  en, flush, valid_i, reg_write_i, mem_to_reg_i, link_i,
           a3_i, tnew_i, pc_i, payload_i,
    output valid_o, reg_write_o, mem_to_reg_o, link_o, a3_o, tnew_o,
           pc_o, pc8_o, payload_o, fwd_ready_o, stall_cnt_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic MIPS inter-stage pipeline register with stall, flush (bubble) and Tnew decrement,
// plus a forward-ready flag and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int NUM_WORDS        = 2,
  parameter int TNEW_W           = 2,
  parameter int DEC_TNEW         = 1,
  parameter int KEEP_PC_ON_FLUSH = 1,
  parameter int CNT_W            = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_reg_if.slave  bus
);

  localparam int PAYLOAD_W = NUM_WORDS * 32;
  localparam logic [TNEW_W-1:0] TNEW_ONE = TNEW_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  if (NUM_WORDS < 1 || NUM_WORDS > 8) begin : g_bad_num_words
    $error("pipe_stage_reg: NUM_WORDS must be in 1..8");
  end

  logic                 valid_q, valid_n;
  logic                 reg_write_q, reg_write_n;
  logic                 mem_to_reg_q, mem_to_reg_n;
  logic                 link_q, link_n;
  logic [4:0]           a3_q, a3_n;
  logic [TNEW_W-1:0]    tnew_q, tnew_n;
  logic [TNEW_W-1:0]    tnew_load;
  logic [31:0]          pc_q, pc_n;
  logic [31:0]          pc8_q, pc8_n;
  logic [PAYLOAD_W-1:0] payload_q, payload_n;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_n;
  logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_n;

  // Next-state selection: flush beats stall beats load; hold is the default.
  always_comb begin
    valid_n      = valid_q;
    reg_write_n  = reg_write_q;
    mem_to_reg_n = mem_to_reg_q;
    link_n       = link_q;
    a3_n         = a3_q;
    tnew_n       = tnew_q;
    pc_n         = pc_q;
    pc8_n        = pc8_q;
    payload_n    = payload_q;
    tnew_load    = bus.tnew_i;

    if (DEC_TNEW != 0) begin
      tnew_load = (bus.tnew_i == '0) ? '0 : (bus.tnew_i - TNEW_ONE);
    end

    if (bus.flush) begin
      valid_n      = 1'b0;
      reg_write_n  = 1'b0;
      mem_to_reg_n = 1'b0;
      link_n       = 1'b0;
      a3_n         = 5'd0;
      tnew_n       = '0;
      payload_n    = '0;
      // Bubbles may keep the PC so a later exception still reports a sensible address.
      if (KEEP_PC_ON_FLUSH != 0) begin
        pc_n  = bus.pc_i;
        pc8_n = bus.pc_i + 32'd8;
      end else begin
        pc_n  = 32'd0;
        pc8_n = 32'd0;
      end
    end else if (bus.en) begin
      valid_n      = bus.valid_i;
      reg_write_n  = bus.reg_write_i & bus.valid_i;
      mem_to_reg_n = bus.mem_to_reg_i;
      link_n       = bus.link_i;
      a3_n         = bus.a3_i;
      tnew_n       = tnew_load;
      pc_n         = bus.pc_i;
      pc8_n        = bus.pc_i + 32'd8;
      payload_n    = bus.payload_i;
    end
  end

  // A flushed edge counts as a bubble only, even when en is low at the same time.
  always_comb begin
    stall_cnt_n  = stall_cnt_q;
    bubble_cnt_n = bubble_cnt_q;
    if (bus.flush) begin
      if (bubble_cnt_q != '1) begin
        bubble_cnt_n = bubble_cnt_q + CNT_ONE;
      end
    end else if (!bus.en) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_n = stall_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      link_q       <= 1'b0;
      a3_q         <= 5'd0;
      tnew_q       <= '0;
      pc_q         <= 32'd0;
      pc8_q        <= 32'd0;
      payload_q    <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_n;
      reg_write_q  <= reg_write_n;
      mem_to_reg_q <= mem_to_reg_n;
      link_q       <= link_n;
      a3_q         <= a3_n;
      tnew_q       <= tnew_n;
      pc_q         <= pc_n;
      pc8_q        <= pc8_n;
      payload_q    <= payload_n;
      stall_cnt_q  <= stall_cnt_n;
      bubble_cnt_q <= bubble_cnt_n;
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.reg_write_o  = reg_write_q;
  assign bus.mem_to_reg_o = mem_to_reg_q;
  assign bus.link_o       = link_q;
  assign bus.a3_o         = a3_q;
  assign bus.tnew_o       = tnew_q;
  assign bus.pc_o         = pc_q;
  assign bus.pc8_o        = pc8_q;
  assign bus.payload_o    = payload_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.bubble_cnt_o = bubble_cnt_q;

  // $0 is hardwired to zero, so a pending write to it is never worth forwarding.
  assign bus.fwd_ready_o = valid_q & reg_write_q & (a3_q != 5'd0) & (tnew_q == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench: dut0 uses default parameters, dut1 uses a 2-bit
// counter, no Tnew decrement and PC zeroing on flush.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset0;
  logic reset1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.NUM_WORDS(2), .TNEW_W(2), .CNT_W(16)) b0 ();
  pipe_stage_reg_if #(.NUM_WORDS(1), .TNEW_W(2), .CNT_W(2))  b1 ();

  pipe_stage_reg #(
    .NUM_WORDS(2), .TNEW_W(2), .DEC_TNEW(1), .KEEP_PC_ON_FLUSH(1), .CNT_W(16)
  ) dut0 (
    .clk(clk), .reset(reset0), .bus(b0.slave)
  );

  pipe_stage_reg #(
    .NUM_WORDS(1), .TNEW_W(2), .DEC_TNEW(0), .KEEP_PC_ON_FLUSH(0), .CNT_W(2)
  ) dut1 (
    .clk(clk), .reset(reset1), .bus(b1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset0 = 1'b1;
    b0.en = 1'b0; b0.flush = 1'b0; b0.valid_i = 1'b1; b0.reg_write_i = 1'b1;
    b0.mem_to_reg_i = 1'b1; b0.link_i = 1'b1; b0.a3_i = 5'd3; b0.tnew_i = 2'd0;
    b0.pc_i = 32'h0000_1234; b0.payload_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    vectors++;
    if (b0.valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_valid got %h expected 0", b0.valid_o);
    end
    vectors++;
    if ({b0.pc_o, b0.pc8_o} !== 64'd0) begin
      miscompares++; $display("[TB] FAIL reset_pc got %h/%h expected 0/0", b0.pc_o, b0.pc8_o);
    end
    vectors++;
    if (b0.payload_o !== 64'd0) begin
      miscompares++; $display("[TB] FAIL reset_payload got %h expected 0", b0.payload_o);
    end
    vectors++;
    if ({b0.stall_cnt_o, b0.bubble_cnt_o} !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_counters got %0d/%0d expected 0/0", b0.stall_cnt_o, b0.bubble_cnt_o);
    end
    vectors++;
    if ({b0.fwd_ready_o, b0.reg_write_o, b0.a3_o, b0.tnew_o} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl got fwd=%b rw=%b a3=%0d tnew=%0d expected all 0",
               b0.fwd_ready_o, b0.reg_write_o, b0.a3_o, b0.tnew_o);
    end
  endtask

  task automatic test_load();
    reset0 = 1'b0;
    b0.en = 1'b1; b0.flush = 1'b0; b0.valid_i = 1'b1; b0.reg_write_i = 1'b1;
    b0.mem_to_reg_i = 1'b0; b0.link_i = 1'b0; b0.a3_i = 5'd5; b0.tnew_i = 2'd2;
    b0.pc_i = 32'h0000_3000; b0.payload_i = {32'hCAFE_BABE, 32'h1234_5678};
    tick();
    vectors++;
    if ({b0.valid_o, b0.reg_write_o, b0.a3_o} !== {1'b1, 1'b1, 5'd5}) begin
      miscompares++;
      $display("[TB] FAIL load_ctrl got v=%b rw=%b a3=%0d expected 1 1 5",
               b0.valid_o, b0.reg_write_o, b0.a3_o);
    end
    vectors++;
    if (b0.tnew_o !== 2'd1) begin
      miscompares++; $display("[TB] FAIL load_tnew_dec got %0d expected 1", b0.tnew_o);
    end
    vectors++;
    if ({b0.pc_o, b0.pc8_o} !== {32'h0000_3000, 32'h0000_3008}) begin
      miscompares++;
      $display("[TB] FAIL load_pc got %h/%h expected 00003000/00003008", b0.pc_o, b0.pc8_o);
    end
    vectors++;
    if (b0.payload_o !== 64'hCAFE_BABE_1234_5678) begin
      miscompares++; $display("[TB] FAIL load_payload got %h expected cafebabe12345678", b0.payload_o);
    end
    vectors++;
    if (b0.fwd_ready_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_fwd got %b expected 0", b0.fwd_ready_o);
    end
  endtask

  task automatic test_fwd_ready();
    b0.tnew_i = 2'd0; b0.a3_i = 5'd5; b0.mem_to_reg_i = 1'b1; b0.link_i = 1'b1;
    tick();
    vectors++;
    if ({b0.tnew_o, b0.fwd_ready_o} !== {2'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL fwd_tnew0 got tnew=%0d fwd=%b expected 0 1", b0.tnew_o, b0.fwd_ready_o);
    end
    vectors++;
    if ({b0.mem_to_reg_o, b0.link_o} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL fwd_m2r_link got %b%b expected 11", b0.mem_to_reg_o, b0.link_o);
    end
    b0.a3_i = 5'd0;
    tick();
    vectors++;
    if ({b0.reg_write_o, b0.fwd_ready_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL fwd_zero_reg got rw=%b fwd=%b expected 1 0", b0.reg_write_o, b0.fwd_ready_o);
    end
  endtask

  task automatic test_stall();
    b0.en = 1'b1; b0.a3_i = 5'd7; b0.tnew_i = 2'd3; b0.pc_i = 32'h0000_3004;
    b0.mem_to_reg_i = 1'b0; b0.link_i = 1'b0;
    b0.payload_i = {32'h0BAD_F00D, 32'hA5A5_A5A5};
    tick();
    b0.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b0.a3_i = 5'(20 + i); b0.tnew_i = 2'(i); b0.pc_i = 32'h0000_4000 + 32'(i);
      b0.payload_i = {32'h1111_1111, 32'(i)};
      tick();
    end
    vectors++;
    if ({b0.a3_o, b0.tnew_o} !== {5'd7, 2'd2}) begin
      miscompares++;
      $display("[TB] FAIL stall_ctrl got a3=%0d tnew=%0d expected 7 2", b0.a3_o, b0.tnew_o);
    end
    vectors++;
    if ({b0.pc_o, b0.pc8_o} !== {32'h0000_3004, 32'h0000_300C}) begin
      miscompares++;
      $display("[TB] FAIL stall_pc got %h/%h expected 00003004/0000300c", b0.pc_o, b0.pc8_o);
    end
    vectors++;
    if (b0.payload_o !== 64'h0BAD_F00D_A5A5_A5A5) begin
      miscompares++; $display("[TB] FAIL stall_payload got %h expected 0badf00da5a5a5a5", b0.payload_o);
    end
    vectors++;
    if (b0.stall_cnt_o !== 16'd3) begin
      miscompares++; $display("[TB] FAIL stall_cnt got %0d expected 3", b0.stall_cnt_o);
    end
  endtask

  task automatic test_flush();
    b0.en = 1'b0; b0.flush = 1'b1; b0.pc_i = 32'h0000_3010;
    b0.valid_i = 1'b1; b0.reg_write_i = 1'b1; b0.a3_i = 5'd9; b0.tnew_i = 2'd2;
    tick();
    vectors++;
    if ({b0.valid_o, b0.reg_write_o, b0.mem_to_reg_o, b0.link_o, b0.a3_o, b0.tnew_o} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL flush_ctrl got v=%b rw=%b a3=%0d tnew=%0d expected all 0",
               b0.valid_o, b0.reg_write_o, b0.a3_o, b0.tnew_o);
    end
    vectors++;
    if (b0.payload_o !== 64'd0) begin
      miscompares++; $display("[TB] FAIL flush_payload got %h expected 0", b0.payload_o);
    end
    vectors++;
    if ({b0.pc_o, b0.pc8_o} !== {32'h0000_3010, 32'h0000_3018}) begin
      miscompares++;
      $display("[TB] FAIL flush_keep_pc got %h/%h expected 00003010/00003018", b0.pc_o, b0.pc8_o);
    end
    vectors++;
    if ({b0.bubble_cnt_o, b0.stall_cnt_o} !== {16'd1, 16'd3}) begin
      miscompares++;
      $display("[TB] FAIL flush_counters got bubble=%0d stall=%0d expected 1 3",
               b0.bubble_cnt_o, b0.stall_cnt_o);
    end
  endtask

  task automatic test_qualify_and_wrap();
    b0.flush = 1'b0; b0.en = 1'b1; b0.valid_i = 1'b0; b0.reg_write_i = 1'b1;
    b0.a3_i = 5'd4; b0.tnew_i = 2'd1; b0.pc_i = 32'h0000_3020;
    tick();
    vectors++;
    if ({b0.valid_o, b0.reg_write_o, b0.a3_o} !== {1'b0, 1'b0, 5'd4}) begin
      miscompares++;
      $display("[TB] FAIL qualify_rw got v=%b rw=%b a3=%0d expected 0 0 4",
               b0.valid_o, b0.reg_write_o, b0.a3_o);
    end
    b0.valid_i = 1'b1; b0.pc_i = 32'hFFFF_FFFC;
    tick();
    vectors++;
    if ({b0.pc_o, b0.pc8_o} !== {32'hFFFF_FFFC, 32'h0000_0004}) begin
      miscompares++;
      $display("[TB] FAIL pc8_wrap got %h/%h expected fffffffc/00000004", b0.pc_o, b0.pc8_o);
    end
    vectors++;
    if ({b0.stall_cnt_o, b0.bubble_cnt_o} !== {16'd3, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL load_no_count got stall=%0d bubble=%0d expected 3 1",
               b0.stall_cnt_o, b0.bubble_cnt_o);
    end
  endtask

  task automatic test_saturate();
    reset1 = 1'b0;
    b1.en = 1'b1; b1.flush = 1'b0; b1.valid_i = 1'b1; b1.reg_write_i = 1'b1;
    b1.mem_to_reg_i = 1'b0; b1.link_i = 1'b1; b1.a3_i = 5'd9; b1.tnew_i = 2'd2;
    b1.pc_i = 32'h0000_0100; b1.payload_i = 32'hDEAD_BEEF;
    tick();
    vectors++;
    if ({b1.tnew_o, b1.pc8_o, b1.payload_o} !== {2'd2, 32'h0000_0108, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("[TB] FAIL nodec_load got tnew=%0d pc8=%h pay=%h expected 2 00000108 deadbeef",
               b1.tnew_o, b1.pc8_o, b1.payload_o);
    end
    b1.en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (b1.stall_cnt_o !== 2'd3) begin
      miscompares++; $display("[TB] FAIL sat_stall_3 got %0d expected 3", b1.stall_cnt_o);
    end
    tick();
    tick();
    vectors++;
    if ({b1.stall_cnt_o, b1.a3_o} !== {2'd3, 5'd9}) begin
      miscompares++;
      $display("[TB] FAIL sat_stall_5 got cnt=%0d a3=%0d expected 3 9", b1.stall_cnt_o, b1.a3_o);
    end
    b1.en = 1'b1; b1.flush = 1'b1; b1.pc_i = 32'h0000_0200;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if ({b1.bubble_cnt_o, b1.stall_cnt_o} !== {2'd3, 2'd3}) begin
      miscompares++;
      $display("[TB] FAIL sat_bubble got bubble=%0d stall=%0d expected 3 3",
               b1.bubble_cnt_o, b1.stall_cnt_o);
    end
    vectors++;
    if ({b1.pc_o, b1.pc8_o} !== 64'd0) begin
      miscompares++; $display("[TB] FAIL flush_zero_pc got %h/%h expected 0/0", b1.pc_o, b1.pc8_o);
    end
    b1.flush = 1'b0; b1.en = 1'b1; b1.pc_i = 32'h0000_0300;
    tick();
    b1.en = 1'b0;
    tick();
    reset1 = 1'b1; b1.flush = 1'b1;
    tick();
    vectors++;
    if ({b1.valid_o, b1.reg_write_o, b1.link_o, b1.a3_o, b1.tnew_o, b1.fwd_ready_o} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL midstall_reset_ctrl got v=%b rw=%b a3=%0d tnew=%0d expected all 0",
               b1.valid_o, b1.reg_write_o, b1.a3_o, b1.tnew_o);
    end
    vectors++;
    if ({b1.pc_o, b1.pc8_o, b1.payload_o, b1.stall_cnt_o, b1.bubble_cnt_o} !== 100'd0) begin
      miscompares++;
      $display("[TB] FAIL midstall_reset_data got pc=%h pc8=%h pay=%h stall=%0d bubble=%0d expected 0",
               b1.pc_o, b1.pc8_o, b1.payload_o, b1.stall_cnt_o, b1.bubble_cnt_o);
    end
  endtask

  initial begin
    reset1 = 1'b1;
    b1.en = 1'b0; b1.flush = 1'b0; b1.valid_i = 1'b0; b1.reg_write_i = 1'b0;
    b1.mem_to_reg_i = 1'b0; b1.link_i = 1'b0; b1.a3_i = 5'd0; b1.tnew_i = 2'd0;
    b1.pc_i = 32'd0; b1.payload_i = 32'd0;
    test_reset();
    test_load();
    test_fwd_ready();
    test_stall();
    test_flush();
    test_qualify_and_wrap();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
